bus_timer_multi: RTL and testbench
==================================

# bus_timer_multi

Multi-channel, bus-mapped interval timer for the microprocessor system: the parametrised successor of the single-channel timer. A shared prescaler generates a time-base tick. Each of NUM_CH channels counts ticks up to a programmable period and raises its own interrupt line, in periodic or one-shot mode. The block sits on the processor data/address bus alongside the other peripherals and is instantiated from Top.

## Interface
- BASE_ADDR, 8'hE0: first bus address; channel c occupies BASE_ADDR+4c … BASE_ADDR+4c+3.
- NUM_CH, 4: channel count, 1..8; must satisfy BASE_ADDR+4*NUM_CH ≤ 256.
- PRESCALE, 100000: CLK cycles per tick, ≥2 (1 ms at 100 MHz).
- CNT_WIDTH, 16: counter/period width, 1..16; period bits above CNT_WIDTH-1 are written but ignored.

- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset; one clock domain, no other clocks.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  1 = write cycle, 0 = read cycle.
- BUS_DATA_IN  in  8  write data from processor.
- BUS_DATA_OUT  out  8  registered read data.
- BUS_DATA_OE  out  1  high when this block drives read data.
- INTERRUPT_RAISE  out  NUM_CH  per-channel pending interrupt, level.
- INTERRUPT_ACK  in  NUM_CH  per-channel acknowledge, single-cycle pulse.

## Operation
- Register map per channel (offset from BASE_ADDR+4c):
  - +0: PERIOD[7:0], R/W.
  - +1: PERIOD[15:8], R/W.
  - +2: CTRL. Bit0 EN, bit1 ONESHOT, R/W; other bits read 0.
  - +3: STATUS, read-only; writes ignored. Bit0 PENDING, bit1 EN, bits[7:2] = COUNT[5:0].
- Prescaler: counts 0..PRESCALE-1 continuously while RESET is high. TICK is a one-cycle pulse in the cycle where the prescaler equals PRESCALE-1; the prescaler wraps to 0 on the next edge.
- Channel on TICK with EN=1 and PERIOD≠0:
  - If COUNT ≥ PERIOD-1: COUNT←0, PENDING←1 (a "fire"); if ONESHOT=1, EN←0.
  - Otherwise COUNT←COUNT+1.
- PERIOD=0: the channel never fires and COUNT is held at 0.
- Channel with EN=0: COUNT holds its value.
- A write to CTRL with EN=1 while EN was 0 clears COUNT to 0 on the same edge. Writing EN=1 while already enabled does not clear COUNT.
- PERIOD writes take effect immediately; COUNT is not reset. Because the compare is ≥, shrinking PERIOD below COUNT+1 fires on the next TICK.
- PENDING clears on INTERRUPT_ACK[c]=1. If a fire and an ACK occur in the same cycle, the fire wins and PENDING stays 1.
- INTERRUPT_RAISE[c] = PENDING[c], driven directly from the flop.
- If a CTRL write and a one-shot auto-clear hit the same edge, the bus write wins.
- Addresses outside the block's range are ignored for both reads and writes.

## Timing
- Reset (RESET=0): prescaler, all PERIOD, CTRL, COUNT and PENDING = 0. BUS_DATA_OUT=8'h00, BUS_DATA_OE=0, INTERRUPT_RAISE=0. Asserting reset mid-count aborts immediately; no interrupt is generated on release.
- Write: a register updates on the CLK edge of the cycle with BUS_WE=1 and an in-range BUS_ADDR; no wait states.
- Read: a cycle with BUS_WE=0 and an in-range address gives BUS_DATA_OUT valid with BUS_DATA_OE=1 in the following cycle (1-cycle latency). OE is 0 in every other cycle. Back-to-back reads are permitted, one per cycle.
- Fire latency: PENDING rises on the edge ending the TICK cycle. With EN set and COUNT=0, the first fire occurs on the PERIOD-th TICK; subsequent periodic fires follow every PERIOD ticks.
- ACK: PENDING falls on the edge ending the ACK cycle; RAISE is low the next cycle.
- Channels are fully independent and may fire in the same cycle.

## Test plan
- Reset and readback: hold RESET=0 for 3 cycles, release. Read all 4*NUM_CH addresses → every value 8'h00, RAISE=0. Write PERIOD0=16'h0203, read +0/+1 → 8'h03/8'h02 one cycle after each address.
- Periodic fire (PRESCALE=4): ch0 PERIOD=3, CTRL=8'h01 → RAISE[0] rises on the 3rd TICK (12 cycles ±prescaler phase). ACK clears it; the next fire follows exactly 12 cycles later.
- One-shot: ch1 PERIOD=2, CTRL=8'h03 → exactly one fire; STATUS reads 8'h01 afterwards (PENDING=1, EN=0); no further fires across 20 ticks.
- Simultaneous fire and ACK: drive ACK[0] in the TICK cycle of a fire → RAISE[0] stays 1 and needs a second ACK to clear.
- Period shrink and zero: while COUNT=5, write PERIOD=2 → fire on the next TICK. PERIOD=0 with EN=1 → no fire over 50 ticks; COUNT reads 0.
- Multi-channel and range: ch0–ch3 enabled with PERIODs 1,2,3,4 → fire pattern matches over 12 ticks. A write to BASE_ADDR+4*NUM_CH changes nothing, and a read there gives OE=0. Async reset mid-run → RAISE=0 immediately.

Source files
------------

// File: rtl/bus_timer_multi.sv
// bus_timer_multi: bus-mapped multi-channel interval timer.
// One shared prescaler tick drives NUM_CH periodic/one-shot counters.
module bus_timer_multi #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_CH    = 4,
    parameter int         PRESCALE  = 100000,
    parameter int         CNT_WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        BUS_ADDR,
    input  logic              BUS_WE,
    input  logic [7:0]        BUS_DATA_IN,
    output logic [7:0]        BUS_DATA_OUT,
    output logic              BUS_DATA_OE,
    output logic [NUM_CH-1:0] INTERRUPT_RAISE,
    input  logic [NUM_CH-1:0] INTERRUPT_ACK
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_ONE = PW'(1);
    localparam logic [8:0] LO = {1'b0, BASE_ADDR};
    localparam logic [8:0] SPAN = 9'(4 * NUM_CH);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;

    always_comb begin
        tick  = (pre_q == PS_LAST);
        pre_d = tick ? '0 : pre_q + PS_ONE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    logic [8:0] addr_ext;
    logic [8:0] off;
    logic       hit;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] sel_ch;
    logic [1:0] sel_reg;

    always_comb begin
        addr_ext = {1'b0, BUS_ADDR};
        off      = addr_ext - LO;
        hit      = (addr_ext >= LO) && (off < SPAN);
        wr_en    = hit && BUS_WE;
        rd_en    = hit && !BUS_WE;
        sel_ch   = off[4:2];
        sel_reg  = off[1:0];
    end

    logic [NUM_CH-1:0][7:0] per_lo;
    logic [NUM_CH-1:0][7:0] per_hi;
    logic [NUM_CH-1:0][7:0] ctrl_rd;
    logic [NUM_CH-1:0][7:0] stat_rd;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [15:0]          per_q;
        logic [15:0]          per_d;
        logic                 en_q;
        logic                 en_d;
        logic                 os_q;
        logic                 os_d;
        logic                 pend_q;
        logic                 pend_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic [CNT_WIDTH-1:0] per_eff;
        logic [5:0]           cnt6;
        logic                 wr_ch;
        logic                 fire;

        if (CNT_WIDTH >= 6) begin : g_wide
            assign cnt6 = cnt_q[5:0];
        end else begin : g_narrow
            assign cnt6 = 6'(cnt_q);
        end

        always_comb begin
            per_eff = per_q[CNT_WIDTH-1:0];
            wr_ch   = wr_en && (sel_ch == 3'(c));
            fire    = tick && en_q && (per_eff != '0)
                      && (cnt_q >= per_eff - C_ONE);
            per_d   = per_q;
            en_d    = en_q;
            os_d    = os_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;

            if (tick && en_q) begin
                if (per_eff == '0) begin
                    cnt_d = '0;
                end else if (fire) begin
                    cnt_d = '0;
                    if (os_q) begin
                        en_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            // Bus write lands after the tick update so it overrides auto-clear.
            if (wr_ch) begin
                case (sel_reg)
                    2'd0: per_d[7:0]  = BUS_DATA_IN;
                    2'd1: per_d[15:8] = BUS_DATA_IN;
                    2'd2: begin
                        en_d = BUS_DATA_IN[0];
                        os_d = BUS_DATA_IN[1];
                        if (BUS_DATA_IN[0] && !en_q) begin
                            cnt_d = '0;
                        end
                    end
                    default: ;
                endcase
            end

            if (fire) begin
                pend_d = 1'b1;
            end else if (INTERRUPT_ACK[c]) begin
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                per_q  <= '0;
                en_q   <= 1'b0;
                os_q   <= 1'b0;
                pend_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                per_q  <= per_d;
                en_q   <= en_d;
                os_q   <= os_d;
                pend_q <= pend_d;
                cnt_q  <= cnt_d;
            end
        end

        assign per_lo[c]          = per_q[7:0];
        assign per_hi[c]          = per_q[15:8];
        assign ctrl_rd[c]         = {6'd0, os_q, en_q};
        assign stat_rd[c]         = {cnt6, en_q, pend_q};
        assign INTERRUPT_RAISE[c] = pend_q;
    end

    logic [7:0] rd_q;
    logic [7:0] rd_d;
    logic       oe_q;
    logic       oe_d;

    always_comb begin
        rd_d = 8'h00;
        oe_d = rd_en;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_en && (sel_ch == 3'(c))) begin
                case (sel_reg)
                    2'd0:    rd_d = per_lo[c];
                    2'd1:    rd_d = per_hi[c];
                    2'd2:    rd_d = ctrl_rd[c];
                    default: rd_d = stat_rd[c];
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_q <= 8'h00;
            oe_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            oe_q <= oe_d;
        end
    end

    assign BUS_DATA_OUT = rd_q;
    assign BUS_DATA_OE  = oe_q;

endmodule

// File: tb/tb_bus_timer_multi.sv
// tb_bus_timer_multi: directed and random checks of bus_timer_multi
// against a cycle-level reference model of the register/timer rules.
module tb_bus_timer_multi;

    localparam logic [7:0] BASE = 8'hE0;
    localparam int NCH = 4;
    localparam int PRE = 4;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic [7:0]     BUS_ADDR = 8'h00;
    logic           BUS_WE = 1'b0;
    logic [7:0]     BUS_DATA_IN = 8'h00;
    logic [7:0]     BUS_DATA_OUT;
    logic           BUS_DATA_OE;
    logic [NCH-1:0] INTERRUPT_RAISE;
    logic [NCH-1:0] INTERRUPT_ACK = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int m_ph;
    int m_per[NCH];
    int m_cnt[NCH];
    bit m_en[NCH];
    bit m_os[NCH];
    bit m_pend[NCH];
    bit m_oe;
    logic [7:0] m_rd;

    bus_timer_multi #(
        .BASE_ADDR(BASE),
        .NUM_CH(NCH),
        .PRESCALE(PRE),
        .CNT_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BUS_ADDR(BUS_ADDR),
        .BUS_WE(BUS_WE),
        .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT),
        .BUS_DATA_OE(BUS_DATA_OE),
        .INTERRUPT_RAISE(INTERRUPT_RAISE),
        .INTERRUPT_ACK(INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_ph = 0;
        m_oe = 0;
        m_rd = 8'h00;
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 0;
            m_cnt[c] = 0;
            m_en[c] = 0;
            m_os[c] = 0;
            m_pend[c] = 0;
        end
    endtask

    function automatic logic [7:0] reg_val(int off);
        int c = off / 4;
        int r = off % 4;
        case (r)
            0: return 8'(m_per[c] % 256);
            1: return 8'(m_per[c] / 256);
            2: return {6'd0, m_os[c], m_en[c]};
            default: return {6'(m_cnt[c] % 64), m_en[c], m_pend[c]};
        endcase
    endfunction

    function automatic logic [NCH-1:0] m_raise();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
        return v;
    endfunction

    // Advance the model across the coming edge using current inputs.
    task automatic model_edge();
        bit tick;
        bit fire;
        bit old_en;
        int off;
        int d;
        if (!RESET) begin
            model_reset();
            return;
        end
        tick = (m_ph == PRE - 1);
        m_ph = tick ? 0 : m_ph + 1;
        off = int'(BUS_ADDR) - int'(BASE);
        d = int'(BUS_DATA_IN);
        m_oe = 0;
        m_rd = 8'h00;
        if (off >= 0 && off < 4 * NCH && !BUS_WE) begin
            m_oe = 1;
            m_rd = reg_val(off);
        end
        for (int c = 0; c < NCH; c++) begin
            fire = 0;
            old_en = m_en[c];
            if (tick && old_en) begin
                if (m_per[c] == 0) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] >= m_per[c] - 1) begin
                    m_cnt[c] = 0;
                    fire = 1;
                    if (m_os[c]) m_en[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (BUS_WE && off >= 0 && off < 4 * NCH && off / 4 == c) begin
                case (off % 4)
                    0: m_per[c] = (m_per[c] / 256) * 256 + d;
                    1: m_per[c] = (m_per[c] % 256) + d * 256;
                    2: begin
                        if (d % 2 == 1 && !old_en) m_cnt[c] = 0;
                        m_en[c] = (d % 2 == 1);
                        m_os[c] = ((d / 2) % 2 == 1);
                    end
                    default: ;
                endcase
            end
            if (fire) m_pend[c] = 1;
            else if (INTERRUPT_ACK[c]) m_pend[c] = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_WE = 1'b1;
        BUS_DATA_IN = d;
        step();
        BUS_WE = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_DATA_IN = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a);
        BUS_ADDR = a;
        BUS_WE = 1'b0;
        step();
        BUS_ADDR = 8'h00;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        INTERRUPT_ACK = '0;
        BUS_WE = 1'b0;
        BUS_ADDR = 8'h00;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (INTERRUPT_RAISE !== '0 || BUS_DATA_OE !== 1'b0 || BUS_DATA_OUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: raise=%b oe=%b dout=%h want 0/0/00",
                     INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT);
        end
        RESET = 1'b1;
        for (int a = 0; a < 4 * NCH; a++) begin
            rd(BASE + 8'(a));
            checks++;
            if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h00) begin
                errors++;
                $display("FAIL reset_read[%0d]: oe=%b dout=%h want 1/00",
                         a, BUS_DATA_OE, BUS_DATA_OUT);
            end
        end
        checks++;
        if (INTERRUPT_RAISE !== '0) begin
            errors++;
            $display("FAIL reset_raise: got %b want 0", INTERRUPT_RAISE);
        end
        wr(BASE, 8'h03);
        wr(BASE + 8'd1, 8'h02);
        rd(BASE);
        checks++;
        if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h03) begin
            errors++;
            $display("FAIL per_lo_rb: oe=%b dout=%h want 1/03", BUS_DATA_OE, BUS_DATA_OUT);
        end
        rd(BASE + 8'd1);
        checks++;
        if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h02) begin
            errors++;
            $display("FAIL per_hi_rb: oe=%b dout=%h want 1/02", BUS_DATA_OE, BUS_DATA_OUT);
        end
    endtask

    task automatic test_periodic();
        int t1;
        int t2;
        int n;
        do_reset();
        wr(BASE, 8'd3);
        wr(BASE + 8'd1, 8'd0);
        wr(BASE + 8'd2, 8'h01);
        n = 0;
        while (!INTERRUPT_RAISE[0] && !m_pend[0] && n < 60) begin
            step();
            n++;
        end
        t1 = cyc;
        checks++;
        if (n >= 60 || INTERRUPT_RAISE[0] !== m_pend[0]) begin
            errors++;
            $display("FAIL per_first: raise=%b want %b (wait %0d)",
                     INTERRUPT_RAISE[0], m_pend[0], n);
        end
        INTERRUPT_ACK[0] = 1'b1;
        step();
        INTERRUPT_ACK[0] = 1'b0;
        checks++;
        if (INTERRUPT_RAISE[0] !== 1'b0) begin
            errors++;
            $display("FAIL per_ack: raise=%b want 0", INTERRUPT_RAISE[0]);
        end
        n = 0;
        while (!INTERRUPT_RAISE[0] && n < 40) begin
            step();
            n++;
        end
        t2 = cyc;
        checks++;
        if (t2 - t1 !== 12) begin
            errors++;
            $display("FAIL per_interval: got %0d cycles want 12", t2 - t1);
        end
    endtask

    task automatic test_oneshot();
        int rises;
        bit prev;
        do_reset();
        wr(BASE + 8'd4, 8'd2);
        wr(BASE + 8'd5, 8'd0);
        wr(BASE + 8'd6, 8'h03);
        rises = 0;
        prev = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (INTERRUPT_RAISE[1] && !prev) rises++;
            prev = INTERRUPT_RAISE[1];
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL oneshot_count: got %0d fires want 1", rises);
        end
        rd(BASE + 8'd7);
        checks++;
        if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h01) begin
            errors++;
            $display("FAIL oneshot_status: oe=%b dout=%h want 1/01",
                     BUS_DATA_OE, BUS_DATA_OUT);
        end
    endtask

    task automatic test_fire_ack();
        int n;
        do_reset();
        wr(BASE, 8'd3);
        wr(BASE + 8'd1, 8'd0);
        wr(BASE + 8'd2, 8'h01);
        n = 0;
        while (!(m_ph == PRE - 1 && m_en[0] && m_cnt[0] >= m_per[0] - 1) && n < 60) begin
            step();
            n++;
        end
        INTERRUPT_ACK[0] = 1'b1;
        step();
        INTERRUPT_ACK[0] = 1'b0;
        checks++;
        if (n >= 60 || INTERRUPT_RAISE[0] !== 1'b1) begin
            errors++;
            $display("FAIL fire_ack_same: raise=%b want 1 (wait %0d)", INTERRUPT_RAISE[0], n);
        end
        INTERRUPT_ACK[0] = 1'b1;
        step();
        INTERRUPT_ACK[0] = 1'b0;
        checks++;
        if (INTERRUPT_RAISE[0] !== 1'b0) begin
            errors++;
            $display("FAIL fire_ack_second: raise=%b want 0", INTERRUPT_RAISE[0]);
        end
    endtask

    task automatic test_shrink_zero();
        int n;
        bit t;
        bit seen;
        do_reset();
        wr(BASE + 8'd8, 8'd10);
        wr(BASE + 8'd10, 8'h01);
        n = 0;
        while (m_cnt[2] != 5 && n < 80) begin
            step();
            n++;
        end
        wr(BASE + 8'd8, 8'd2);
        n = 0;
        t = 0;
        while (!t && n < 10) begin
            t = (m_ph == PRE - 1);
            step();
            n++;
        end
        checks++;
        if (INTERRUPT_RAISE[2] !== 1'b1) begin
            errors++;
            $display("FAIL shrink_fire: raise=%b want 1", INTERRUPT_RAISE[2]);
        end
        wr(BASE + 8'd8, 8'd0);
        INTERRUPT_ACK[2] = 1'b1;
        step();
        INTERRUPT_ACK[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (INTERRUPT_RAISE[2] !== 1'b0) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_nofire: raise seen=%b want 0", seen);
        end
        rd(BASE + 8'd11);
        checks++;
        if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h02) begin
            errors++;
            $display("FAIL zero_status: oe=%b dout=%h want 1/02", BUS_DATA_OE, BUS_DATA_OUT);
        end
    endtask

    task automatic test_multi();
        int n;
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            wr(BASE + 8'(4 * c), 8'(c + 1));
            wr(BASE + 8'(4 * c + 1), 8'd0);
        end
        for (int c = 0; c < NCH; c++) wr(BASE + 8'(4 * c + 2), 8'h01);
        for (int i = 0; i < 48; i++) begin
            step();
            checks++;
            if (INTERRUPT_RAISE !== m_raise()) begin
                errors++;
                $display("FAIL multi_pattern@%0d: raise=%b want %b",
                         i, INTERRUPT_RAISE, m_raise());
            end
            INTERRUPT_ACK = INTERRUPT_RAISE;
        end
        INTERRUPT_ACK = '0;
        wr(BASE + 8'(4 * NCH), 8'hFF);
        wr(BASE - 8'd1, 8'hFF);
        rd(BASE + 8'(4 * NCH));
        checks++;
        if (BUS_DATA_OE !== 1'b0) begin
            errors++;
            $display("FAIL range_read: oe=%b want 0", BUS_DATA_OE);
        end
        for (int a = 0; a < 4 * NCH; a++) begin
            rd(BASE + 8'(a));
            checks++;
            if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== m_rd) begin
                errors++;
                $display("FAIL range_regs[%0d]: oe=%b dout=%h want 1/%h",
                         a, BUS_DATA_OE, BUS_DATA_OUT, m_rd);
            end
        end
        n = 0;
        while (INTERRUPT_RAISE == '0 && n < 20) begin
            step();
            n++;
        end
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        checks++;
        if (n >= 20 || INTERRUPT_RAISE !== '0) begin
            errors++;
            $display("FAIL async_reset: raise=%b want 0 (wait %0d)", INTERRUPT_RAISE, n);
        end
        step();
        step();
        RESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (INTERRUPT_RAISE !== '0) begin
                errors++;
                $display("FAIL post_reset@%0d: raise=%b want 0", i, INTERRUPT_RAISE);
            end
        end
    endtask

    task automatic test_random();
        int off;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            off = int'($urandom_range(0, 4 * NCH + 3)) - 2;
            BUS_ADDR = 8'(int'(BASE) + off);
            BUS_WE = $urandom_range(0, 1) == 1;
            case ((off + 4) % 4)
                0: BUS_DATA_IN = 8'($urandom_range(0, 5));
                1: BUS_DATA_IN = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
                2: BUS_DATA_IN = 8'($urandom);
                default: BUS_DATA_IN = 8'($urandom);
            endcase
            INTERRUPT_ACK = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
            step();
            checks++;
            if (INTERRUPT_RAISE !== m_raise() || BUS_DATA_OE !== m_oe
                || (m_oe && BUS_DATA_OUT !== m_rd)) begin
                errors++;
                $display("FAIL random@%0d: raise=%b oe=%b dout=%h want %b/%b/%h",
                         i, INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT,
                         m_raise(), m_oe, m_rd);
            end
        end
        BUS_WE = 1'b0;
        BUS_ADDR = 8'h00;
        INTERRUPT_ACK = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_fire_ack();
        test_shrink_zero();
        test_multi();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
